// File: rtl/cap_stream_bridge.sv
// cap_stream_bridge
//   Stream-side transmitter/receiver around the packed-lane filter wrapper.
//   Collects NUM pixels from a valid/ready source into the packed `flow` word,
//   fires a one-cycle `enable`, waits for the filter's `ready`, captures
//   `result`, and drains it highest lane first to a valid/ready sink.
//
// Optional feature macro: CAP_WDOG_EN
//   When defined, a watchdog aborts a WAIT that lasts TIMEOUT cycles without
//   `ready`, pulses `clear` and sets the sticky `err` flag. When undefined,
//   `err` is tied 0 and WAIT lasts until `ready`.
//
// Ports
//   clk, areset          clock (rising edge), asynchronous active-high reset
//   s_valid/s_ready/s_data   input pixel stream
//   m_valid/m_ready/m_data   output pixel stream
//   flush                synchronous batch abort (priority over handshakes)
//   cfg_mode/omega/epsilon   filter configuration, latched on last input pixel
//   flow, mode, omega, epsilon, enable, clear   to filter wrapper
//   result, ready        from filter wrapper
//   err                  sticky watchdog error

module cap_stream_bridge #(
    parameter int unsigned SIZE    = 3,
    parameter int unsigned NUM     = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          areset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [(1<<SIZE)-1:0]          s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [(1<<SIZE)-1:0]          m_data,
    input  logic                          flush,
    input  logic [1:0]                    cfg_mode,
    input  logic [(1<<SIZE)-1:0]          cfg_omega,
    input  logic [(1<<SIZE)-1:0]          cfg_epsilon,
    output logic [NUM*(1<<SIZE)-1:0]      flow,
    output logic [1:0]                    mode,
    output logic [(1<<SIZE)-1:0]          omega,
    output logic [(1<<SIZE)-1:0]          epsilon,
    output logic                          enable,
    output logic                          clear,
    input  logic [NUM*(1<<SIZE)-1:0]      result,
    input  logic                          ready,
    output logic                          err
);

    localparam int unsigned W    = 1 << SIZE;
    localparam int unsigned CntW = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {
        StFill,
        StFire,
        StWait,
        StDrain
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [NUM*W-1:0]    flow_q, flow_d;
    logic [NUM*W-1:0]    res_q, res_d;
    logic [1:0]          mode_q, mode_d;
    logic [W-1:0]        omega_q, omega_d;
    logic [W-1:0]        epsilon_q, epsilon_d;
    logic                clear_q, clear_d;
    logic [CntW-1:0]     lane_idx;

`ifdef CAP_WDOG_EN
    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic                err_q, err_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Highest lane leaves first.
    assign lane_idx = CntW'(NUM - 1) - cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flow_d    = flow_q;
        res_d     = res_q;
        mode_d    = mode_q;
        omega_d   = omega_q;
        epsilon_d = epsilon_q;
        clear_d   = 1'b0;
`ifdef CAP_WDOG_EN
        wdog_d    = '0;
        err_d     = err_q;
`endif
        if (flush) begin
            // Abort wins over any accept/transfer; flow and config are kept.
            state_d = StFill;
            cnt_d   = '0;
            clear_d = 1'b1;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (s_valid) begin
                        flow_d[cnt_q*W +: W] = s_data;
                        if (cnt_q == CntW'(NUM - 1)) begin
                            mode_d    = cfg_mode;
                            omega_d   = cfg_omega;
                            epsilon_d = cfg_epsilon;
                            cnt_d     = '0;
                            state_d   = StFire;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StFire: begin
                    state_d = StWait;
                end
                StWait: begin
                    if (ready) begin
                        res_d   = result;
                        state_d = StDrain;
                    end
`ifdef CAP_WDOG_EN
                    // ready on the limit cycle still wins (checked above).
                    else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
                        clear_d = 1'b1;
                        err_d   = 1'b1;
                        state_d = StFill;
                    end else begin
                        wdog_d = wdog_q + WdogW'(1);
                    end
`endif
                end
                StDrain: begin
                    if (m_ready) begin
                        if (cnt_q == CntW'(NUM - 1)) begin
                            cnt_d   = '0;
                            state_d = StFill;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= StFill;
            cnt_q     <= '0;
            flow_q    <= '0;
            res_q     <= '0;
            mode_q    <= '0;
            omega_q   <= '0;
            epsilon_q <= '0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flow_q    <= flow_d;
            res_q     <= res_d;
            mode_q    <= mode_d;
            omega_q   <= omega_d;
            epsilon_q <= epsilon_d;
            clear_q   <= clear_d;
        end
    end

`ifdef CAP_WDOG_EN
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Input is refused during reset and on a flush cycle so the handshake
    // never reports a pixel that the abort discards.
    assign s_ready = (state_q == StFill) && !areset && !flush;
    assign m_valid = (state_q == StDrain);
    assign m_data  = m_valid ? res_q[lane_idx*W +: W] : '0;
    assign enable  = (state_q == StFire);
    assign clear   = clear_q;
    assign flow    = flow_q;
    assign mode    = mode_q;
    assign omega   = omega_q;
    assign epsilon = epsilon_q;

endmodule

// File: doc/cap_stream_bridge.md
Name: cap_stream_bridge

Overview:
- Stream-side companion to the packed-lane filter wrapper: the transmitter/receiver pair around it.
- Serialises incoming pixels into a NUM-lane `flow` word and issues a one-cycle `enable`.
- Waits for the filter's `ready`, then captures `result` and drains it back as a serial pixel stream.
- Sits between a valid/ready pixel source/sink and the filter wrapper; the filter ports connect 1:1.

Parameters:
- SIZE, 3, log2 of pixel width; pixel width W = 2**SIZE bits.
- NUM, 4, lanes per batch; packed bus width = NUM*W.
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles. Used only with CAP_WDOG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- areset  in  1  asynchronous, active-high reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  bridge accepts input pixel.
- s_data  in  W  input pixel.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  sink accepts output pixel.
- m_data  out  W  output pixel.
- flush  in  1  synchronous abort of the current batch.
- cfg_mode  in  2  filter mode; sampled on the last input pixel accepted.
- cfg_omega  in  W  filter omega; sampled on the last input pixel accepted.
- cfg_epsilon  in  W  filter epsilon; sampled on the last input pixel accepted.
- flow  out  NUM*W  packed pixels; lane i = bits [(i+1)*W-1 : i*W].
- mode  out  2  latched cfg_mode.
- omega  out  W  latched cfg_omega.
- epsilon  out  W  latched cfg_epsilon.
- enable  out  1  one-cycle start pulse to the filter.
- clear  out  1  one-cycle filter clear pulse.
- result  in  NUM*W  packed filter output.
- ready  in  1  filter result valid (level).
- err  out  1  sticky watchdog error. Tied 0 when CAP_WDOG_EN is undefined.

Behaviour:
- Reset (async, areset=1): state FILL, lane counter 0, all outputs 0 (flow, mode, omega, epsilon, enable, clear, m_valid, m_data, err). s_ready = 0 while areset is high.
- Reset mid-batch discards all buffered data; there is no partial recovery.
- FILL:
  - s_ready=1.
  - On s_valid & s_ready, s_data is written into flow lane cnt and cnt increments.
  - When the pixel in lane NUM-1 is accepted: cfg_* are latched into mode/omega/epsilon, cnt clears, next state FIRE.
  - flow holds its value in all other states.
- FIRE:
  - enable=1 for exactly one cycle; s_ready=0.
  - Next state WAIT unconditionally. `ready` is ignored in this cycle.
- WAIT:
  - enable=0.
  - First cycle with ready=1: result is registered into an internal buffer, next state DRAIN.
  - flow, mode, omega and epsilon stay stable until DRAIN exits.
- DRAIN:
  - m_valid=1; m_data = buffered result lane NUM-1-cnt, so the highest lane is emitted first.
  - On m_valid & m_ready, cnt increments.
  - After lane 0 is transferred: cnt=0, next state FILL. The next batch can be accepted in the cycle following the last transfer.
  - m_data is stable while m_valid=1 and m_ready=0.
- Latency, last input accepted to first m_valid: 2 + (cycles until ready) cycles.
- Throughput: one pixel per cycle per direction. Input and output phases never overlap.
- flush:
  - Valid in any state and has priority over a simultaneous accept or transfer.
  - Next cycle: clear=1 for one cycle, state FILL, cnt 0, m_valid 0.
  - flow and the config registers keep their values; err is unchanged.
- flush asserted during FIRE: the enable pulse still occurs in that cycle, and clear follows in the next cycle.
- Counter: $clog2(NUM) bits, minimum 1. It wraps only through the explicit return to 0; no free-running wrap.

Optional Feature:
- Macro: CAP_WDOG_EN.
- When defined:
  - A watchdog counter runs only in WAIT.
  - If ready has not been seen after TIMEOUT cycles in WAIT: clear=1 for one cycle, err=1 (sticky until areset), state FILL, batch discarded, no output emitted.
  - ready=1 in the same cycle the limit is reached counts as success; the watchdog is not triggered.
- When undefined: no counter is instantiated, err is tied 0, and WAIT waits for ready indefinitely.

Test Plan:
- Basic batch (SIZE=3, NUM=4):
  - Stimulus: feed 0x11,0x22,0x33,0x44 back-to-back; ready rises 5 cycles after enable; result=0xD4C3B2A1.
  - Required: flow=0x44332211; exactly one enable pulse; m_data sequence 0xD4,0xC3,0xB2,0xA1.
- Backpressure:
  - Stimulus: toggle m_ready 1,0,0,1,... during DRAIN.
  - Required: m_data holds while stalled; exactly 4 transfers in order; s_ready=0 until the last transfer, then 1.
- Config latch:
  - Stimulus: change cfg_mode 1→2 between pixel 3 and pixel 4.
  - Required: mode=2 at enable; mode stays 2 through DRAIN even if cfg_mode changes again.
- Flush mid-fill:
  - Stimulus: flush after 2 pixels accepted, with s_valid=1 in the same cycle.
  - Required: that pixel is not accepted; clear pulse next cycle; a following 4-pixel batch produces flow built only from the new pixels.
- Reset mid-WAIT:
  - Stimulus: assert areset asynchronously (between clock edges) during WAIT.
  - Required: outputs 0 immediately; after release, state FILL and s_ready=1; a late ready causes no m_valid.
- Watchdog (CAP_WDOG_EN, TIMEOUT=8):
  - Stimulus: hold ready=0 in WAIT.
  - Required: clear pulse after 8 WAIT cycles; err=1 and stays 1; the next batch completes normally with err still 1.
